max_stream_sequencer: RTL and testbench



---
 rtl/max_stream_sequencer_if.sv | 28 ++
 rtl/max_stream_sequencer.sv | 122 ++++++++++++
 tb/tb_max_stream_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_stream_sequencer_if.sv
// Stream bundle for max_stream_sequencer: word input, frame-result output, flush and busy.
// master is the environment side, slave is the sequencer.
interface max_stream_sequencer_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
);
    localparam int unsigned IW = $clog2(M);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_max;
    logic [IW-1:0] out_index;
    logic          busy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_index, busy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_index, busy
    );
endinterface

// File: rtl/max_stream_sequencer.sv
// Finds the largest of M serial unsigned words per frame using one shared two-input
// comparator, and reports the first beat position holding that maximum.
module max_stream_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    max_stream_sequencer_if.slave  bus
);
    localparam int unsigned IW = $clog2(M);
    localparam int unsigned CW = $clog2(M) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  max_q, max_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_max_q, res_max_d;
    logic [IW-1:0] res_idx_q, res_idx_d;

    logic in_ready;
    logic accept;
    logic larger;

    // Unsigned magnitude compare decided at the most significant differing bit.
    function automatic logic is_larger(input logic [N-1:0] a, input logic [N-1:0] b);
        logic decided;
        logic res;
        decided = 1'b0;
        res     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                res     = a[i];
            end
        end
        return res;
    endfunction

    assign in_ready = (state_q != StDone) && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign larger   = is_larger(bus.in_data, max_q);

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        res_max_d = res_max_q;
        res_idx_d = res_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.flush) begin
                    cnt_d = '0;
                end else if (accept) begin
                    max_d   = bus.in_data;
                    idx_d   = '0;
                    cnt_d   = CW'(1);
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (accept) begin
                    // Strict compare keeps the earliest index on ties.
                    if (larger) begin
                        max_d = bus.in_data;
                        idx_d = cnt_q[IW-1:0];
                    end
                    if (cnt_q == CW'(M - 1)) begin
                        res_max_d = larger ? bus.in_data : max_q;
                        res_idx_d = larger ? cnt_q[IW-1:0] : idx_q;
                        cnt_d     = '0;
                        state_d   = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StDone: begin
                // flush is ignored here so a finished result is never dropped.
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            max_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            res_max_q <= '0;
            res_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            res_max_q <= res_max_d;
            res_idx_q <= res_idx_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StAccum);
    assign bus.out_max   = res_max_q;
    assign bus.out_index = res_idx_q;

endmodule

// File: tb/tb_max_stream_sequencer.sv
// Scoreboard bench for max_stream_sequencer (N=8, M=4): directed scenarios plus a
// randomized regression against a max/first-index reference model.
module tb_max_stream_sequencer;
    logic clk;
    logic rst_n;

    max_stream_sequencer_if #(.N(8), .M(4)) bus ();

    max_stream_sequencer #(.N(8), .M(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total;
    int   passed;
    bit   abort_rand;
    logic [9:0] exp_q[$];

    // Drives one beat after 'gap' idle cycles; starts and ends at a falling edge.
    task automatic drive_beat(input logic [7:0] d, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            $display("FAIL beat_accept_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits for a result, holds out_ready low for 'hold' cycles, then handshakes.
    task automatic collect(input int hold, output logic [7:0] mx, output logic [1:0] ix,
                           output bit ok);
        int n;
        n = 0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = bus.out_valid;
        for (int h = 0; h < hold; h++) @(negedge clk);
        mx = bus.out_max;
        ix = bus.out_index;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_max !== 8'h00) $display("FAIL reset_out_max: got %h want 00", bus.out_max); else passed++;
        total++; if (bus.out_index !== 2'd0) $display("FAIL reset_out_index: got %0d want 0", bus.out_index); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [9:0] e;
        logic [7:0] beats [4];
        beats = '{8'h12, 8'h9A, 8'h34, 8'h56};
        exp_q.push_back({8'h9A, 2'd1});
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_beat(beats[i], 0);
        e = exp_q.pop_front();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%0b want 1", bus.out_valid); else passed++;
        total++; if ({bus.out_max, bus.out_index} !== e)
            $display("FAIL basic_result: got %h/%0d want %h/%0d", bus.out_max, bus.out_index, e[9:2], e[1:0]);
        else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_done_in_ready: got %0b want 0", bus.in_ready); else passed++;
        @(negedge clk);
        total++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010)
            $display("FAIL basic_one_cycle_valid: v/r/b=%b want 010", {bus.out_valid, bus.in_ready, bus.busy});
        else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_tie();
        logic [7:0] mx;
        logic [1:0] ix;
        logic [9:0] e;
        bit ok;
        logic [7:0] f [8];
        f = '{8'h80, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({8'h80, 2'd0});
        exp_q.push_back({8'h00, 2'd0});
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) drive_beat(f[k*4+i], 0);
            collect(0, mx, ix, ok);
            e = exp_q.pop_front();
            total++; if (!ok || {mx, ix} !== e)
                $display("FAIL tie_frame%0d: got %h/%0d ok=%0b want %h/%0d", k, mx, ix, ok, e[9:2], e[1:0]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] mx;
        logic [1:0] ix;
        logic [9:0] e;
        bit ok;
        logic [7:0] f [4];
        f = '{8'h01, 8'h02, 8'h03, 8'hFF};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(f[i], 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int k = 0; k < 5; k++) begin
            bus.flush = (k == 2);
            #1;
            total++; if ({bus.out_valid, bus.in_ready, bus.out_max, bus.out_index} !== {2'b10, 8'hFF, 2'd3})
                $display("FAIL bp_hold%0d: v/r/max/idx=%b/%b/%h/%0d want 1/0/ff/3",
                         k, bus.out_valid, bus.in_ready, bus.out_max, bus.out_index);
            else passed++;
            @(negedge clk);
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_done_no_accept: in_ready=%0b want 0", bus.in_ready); else passed++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010)
            $display("FAIL bp_idle_after: v/r/b=%b want 010", {bus.out_valid, bus.in_ready, bus.busy});
        else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL bp_held_beat_accepted: busy=%0b want 1", bus.busy); else passed++;
        exp_q.push_back({8'h60, 2'd2});
        drive_beat(8'h20, 0);
        drive_beat(8'h60, 0);
        drive_beat(8'h10, 0);
        collect(1, mx, ix, ok);
        e = exp_q.pop_front();
        total++; if (!ok || {mx, ix} !== e)
            $display("FAIL bp_followup: got %h/%0d ok=%0b want %h/%0d", mx, ix, ok, e[9:2], e[1:0]);
        else passed++;
    endtask

    task automatic test_flush();
        logic [7:0] mx;
        logic [1:0] ix;
        logic [9:0] e;
        bit ok;
        logic [7:0] f [4];
        f = '{8'h05, 8'h06, 8'h07, 8'h04};
        drive_beat(8'hF0, 0);
        drive_beat(8'h10, 0);
        total++; if (bus.busy !== 1'b1) $display("FAIL flush_pre_busy: got %0b want 1", bus.busy); else passed++;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); else passed++;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL flush_busy: got %0b want 0", bus.busy); else passed++;
        exp_q.push_back({8'h07, 2'd2});
        for (int i = 0; i < 4; i++) drive_beat(f[i], 0);
        collect(0, mx, ix, ok);
        e = exp_q.pop_front();
        total++; if (!ok || {mx, ix} !== e)
            $display("FAIL flush_no_leak: got %h/%0d ok=%0b want %h/%0d", mx, ix, ok, e[9:2], e[1:0]);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [7:0] mx;
        logic [1:0] ix;
        logic [9:0] e;
        bit ok;
        logic [7:0] f [4];
        f = '{8'h03, 8'h09, 8'h09, 8'h01};
        drive_beat(8'hF0, 0);
        drive_beat(8'h01, 0);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010)
            $display("FAIL rst_accum: b/r/v=%b want 010", {bus.busy, bus.in_ready, bus.out_valid});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        drive_beat(8'hA0, 0);
        drive_beat(8'hB0, 0);
        drive_beat(8'hC0, 0);
        drive_beat(8'hD0, 0);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_done: out_valid=%0b want 1", bus.out_valid); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.out_valid, bus.out_max, bus.out_index, bus.busy, bus.in_ready} !== {1'b0, 8'h00, 2'd0, 2'b01})
            $display("FAIL rst_done: v/max/idx/b/r=%b/%h/%0d/%b/%b want 0/00/0/0/1",
                     bus.out_valid, bus.out_max, bus.out_index, bus.busy, bus.in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({8'h09, 2'd1});
        for (int i = 0; i < 4; i++) drive_beat(f[i], 0);
        collect(0, mx, ix, ok);
        e = exp_q.pop_front();
        total++; if (!ok || {mx, ix} !== e)
            $display("FAIL rst_recover: got %h/%0d ok=%0b want %h/%0d", mx, ix, ok, e[9:2], e[1:0]);
        else passed++;
    endtask

    task automatic rand_driver(input int frames);
        logic [7:0] b [4];
        logic [7:0] base;
        logic [7:0] m;
        logic [1:0] mi;
        int mode;
        for (int f = 0; f < frames && !abort_rand; f++) begin
            mode = f % 3;
            base = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) begin
                if (mode == 0) b[i] = 8'($urandom_range(0, 255));
                else if (mode == 1) b[i] = base ^ 8'($urandom_range(0, 3));   // LSB-decided, frequent ties
                else b[i] = {1'($urandom_range(0, 1)), base[6:0]};            // MSB-decided
            end
            m  = b[0];
            mi = 2'd0;
            for (int i = 1; i < 4; i++) begin
                if (b[i] > m) begin
                    m  = b[i];
                    mi = 2'(i);
                end
            end
            exp_q.push_back({m, mi});
            for (int i = 0; i < 4; i++) drive_beat(b[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
    endtask

    task automatic test_random();
        int frames;
        frames = 1000;
        abort_rand = 1'b0;
        fork
            rand_driver(frames);
            begin
                logic [7:0] mx;
                logic [1:0] ix;
                logic [9:0] e;
                bit ok;
                for (int r = 0; r < frames && !abort_rand; r++) begin
                    collect($urandom_range(0, 3), mx, ix, ok);
                    total++;
                    if (!ok || exp_q.size() == 0) begin
                        $display("FAIL rand_timeout_%0d: ok=%0b queued=%0d want result", r, ok, exp_q.size());
                        abort_rand = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        if ({mx, ix} !== e)
                            $display("FAIL rand_frame_%0d: got %h/%0d want %h/%0d", r, mx, ix, e[9:2], e[1:0]);
                        else passed++;
                    end
                end
            end
        join
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
